// File: rtl/comp_move_gen.sv
// Tic-tac-toe computer move generator: scans a snapshot of the board for a win, then a block, then a preference cell.
// Optional build macro COMP_BLOCK_EN enables the BLOCK phase; when undefined, WIN exhaustion goes straight to PREF.
module comp_move_gen #(
    parameter int PREF_CENTER = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    output logic [3:0] comp_pos,
    output logic       pc,
    output logic       no_move,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WIN    = 3'd1,
        BLOCK  = 3'd2,
        PREF   = 3'd3,
        DONE   = 3'd4,
        NOMOVE = 3'd5
    } state_t;

    localparam logic [1:0] CELL_EMPTY    = 2'b00;
    localparam logic [1:0] CELL_PLAYER   = 2'b01;
    localparam logic [1:0] CELL_COMPUTER = 2'b10;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  idx_r;
    logic [3:0]  idx_s;
    logic [17:0] board_r;
    logic [1:0]  who_s;
    logic [4:0]  line_hit_s;
    logic [3:0]  pref_cell_s;
    logic        hit_s;
    logic [3:0]  hit_cell_s;
    logic        pc_r;
    logic        no_move_r;
    logic        busy_r;
    logic [3:0]  comp_pos_r;
    logic        pc_s;
    logic        no_move_s;
    logic        busy_s;
    logic [3:0]  comp_pos_s;

    // Cell indices of a line, packed as {first, second, third}.
    function automatic logic [11:0] line_cells(input logic [2:0] line);
        case (line)
            3'd0:    return {4'd0, 4'd1, 4'd2};
            3'd1:    return {4'd3, 4'd4, 4'd5};
            3'd2:    return {4'd6, 4'd7, 4'd8};
            3'd3:    return {4'd0, 4'd3, 4'd6};
            3'd4:    return {4'd1, 4'd4, 4'd7};
            3'd5:    return {4'd2, 4'd5, 4'd8};
            3'd6:    return {4'd0, 4'd4, 4'd8};
            3'd7:    return {4'd2, 4'd4, 4'd6};
            default: return {4'd0, 4'd1, 4'd2};
        endcase
    endfunction

    function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] i);
        logic [17:0] sh;
        sh = b >> {i, 1'b0};
        return sh[1:0];
    endfunction

    // Returns {hit, empty_cell}: exactly two cells owned by 'who' and one empty.
    function automatic logic [4:0] line_test(input logic [17:0] b, input logic [2:0] line,
                                             input logic [1:0] who);
        logic [11:0] cells;
        logic [1:0]  v0;
        logic [1:0]  v1;
        logic [1:0]  v2;
        logic [1:0]  n_who;
        logic [1:0]  n_empty;
        logic [3:0]  empty_cell;
        cells   = line_cells(line);
        v0      = cell_of(b, cells[11:8]);
        v1      = cell_of(b, cells[7:4]);
        v2      = cell_of(b, cells[3:0]);
        n_who   = 2'(v0 == who) + 2'(v1 == who) + 2'(v2 == who);
        n_empty = 2'(v0 == CELL_EMPTY) + 2'(v1 == CELL_EMPTY) + 2'(v2 == CELL_EMPTY);
        if (v0 == CELL_EMPTY) begin
            empty_cell = cells[11:8];
        end else if (v1 == CELL_EMPTY) begin
            empty_cell = cells[7:4];
        end else begin
            empty_cell = cells[3:0];
        end
        return {(n_who == 2'd2) && (n_empty == 2'd1), empty_cell};
    endfunction

    function automatic logic [3:0] pref_cell(input logic [3:0] j);
        if (PREF_CENTER != 0) begin
            case (j)
                4'd0:    return 4'd4;
                4'd1:    return 4'd0;
                4'd2:    return 4'd2;
                4'd3:    return 4'd6;
                4'd4:    return 4'd8;
                4'd5:    return 4'd1;
                4'd6:    return 4'd3;
                4'd7:    return 4'd5;
                4'd8:    return 4'd7;
                default: return 4'd0;
            endcase
        end else begin
            return j;
        end
    endfunction

    // Candidate evaluation for the current scan step; idx 9 in PREF is the exhausted marker.
    always_comb begin
        who_s       = (state_r == BLOCK) ? CELL_PLAYER : CELL_COMPUTER;
        line_hit_s  = line_test(board_r, idx_r[2:0], who_s);
        pref_cell_s = pref_cell(idx_r);
        if (state_r == PREF) begin
            hit_s      = (idx_r < 4'd9) && (cell_of(board_r, pref_cell_s) == CELL_EMPTY);
            hit_cell_s = pref_cell_s;
        end else begin
            hit_s      = line_hit_s[4];
            hit_cell_s = line_hit_s[3:0];
        end
    end

    // State, scan index and board snapshot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= 4'd0;
            board_r <= 18'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            if ((state_r == IDLE) && start) begin
                board_r <= {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
            end else begin
                board_r <= board_r;
            end
        end
    end

    // Next-state and next-index logic.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            IDLE: begin
                idx_s = 4'd0;
                if (start) begin
                    state_s = WIN;
                end else begin
                    state_s = IDLE;
                end
            end
            WIN: begin
                if (hit_s) begin
                    state_s = DONE;
                    idx_s   = 4'd0;
                end else if (idx_r == 4'd7) begin
`ifdef COMP_BLOCK_EN
                    state_s = BLOCK;
`else
                    state_s = PREF;
`endif
                    idx_s   = 4'd0;
                end else begin
                    idx_s = idx_r + 4'd1;
                end
            end
`ifdef COMP_BLOCK_EN
            BLOCK: begin
                if (hit_s) begin
                    state_s = DONE;
                    idx_s   = 4'd0;
                end else if (idx_r == 4'd7) begin
                    state_s = PREF;
                    idx_s   = 4'd0;
                end else begin
                    idx_s = idx_r + 4'd1;
                end
            end
`endif
            PREF: begin
                if (idx_r == 4'd9) begin
                    state_s = NOMOVE;
                    idx_s   = 4'd0;
                end else if (hit_s) begin
                    state_s = DONE;
                    idx_s   = 4'd0;
                end else begin
                    idx_s = idx_r + 4'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
                idx_s   = 4'd0;
            end
            NOMOVE: begin
                state_s = IDLE;
                idx_s   = 4'd0;
            end
            default: begin
                state_s = IDLE;
                idx_s   = 4'd0;
            end
        endcase
    end

    // Output decode from the next state so the registered strobes line up with DONE/NOMOVE.
    always_comb begin
        pc_s       = (state_s == DONE);
        no_move_s  = (state_s == NOMOVE);
        busy_s     = (state_s != IDLE);
        if (state_s == DONE) begin
            comp_pos_s = hit_cell_s;
        end else if (state_s == NOMOVE) begin
            comp_pos_s = 4'hF;
        end else begin
            comp_pos_s = comp_pos_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= 1'b0;
            no_move_r  <= 1'b0;
            busy_r     <= 1'b0;
            comp_pos_r <= 4'hF;
        end else begin
            pc_r       <= pc_s;
            no_move_r  <= no_move_s;
            busy_r     <= busy_s;
            comp_pos_r <= comp_pos_s;
        end
    end

    assign pc       = pc_r;
    assign no_move  = no_move_r;
    assign busy     = busy_r;
    assign comp_pos = comp_pos_r;

endmodule

// File: tb/tb_comp_move_gen.sv
// Directed bench for comp_move_gen; expected cycles follow the COMP_BLOCK_EN build setting.
module tb_comp_move_gen;

`ifdef COMP_BLOCK_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif

    localparam logic [1:0] E = 2'b00;
    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] C = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [17:0] bd;
    logic [3:0]  comp_pos;
    logic        pc;
    logic        no_move;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    comp_move_gen #(.PREF_CENTER(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pos1     (bd[1:0]),
        .pos2     (bd[3:2]),
        .pos3     (bd[5:4]),
        .pos4     (bd[7:6]),
        .pos5     (bd[9:8]),
        .pos6     (bd[11:10]),
        .pos7     (bd[13:12]),
        .pos8     (bd[15:14]),
        .pos9     (bd[17:16]),
        .comp_pos (comp_pos),
        .pc       (pc),
        .no_move  (no_move),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] pk(input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] a3,
                                       input logic [1:0] a4, input logic [1:0] a5, input logic [1:0] a6,
                                       input logic [1:0] a7, input logic [1:0] a8, input logic [1:0] a9);
        return {a9, a8, a7, a6, a5, a4, a3, a2, a1};
    endfunction

    // One request; cycle 0 is the cycle in which start is sampled.
    task automatic run_move(input string tag, input logic [17:0] b, input int exp_cyc,
                            input logic exp_pc, input logic [3:0] exp_pos);
        int first;
        int pulses;
        int both;
        logic kind;
        logic [3:0] seen;
        first = -1; pulses = 0; both = 0; kind = 1'b0; seen = 4'd0;
        @(negedge clk);
        bd = b;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (pc && no_move) both++;
            if (pc || no_move) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    kind  = pc;
                    seen  = comp_pos;
                end
            end
        end
        chk({tag, "/cycle"}, first, exp_cyc);
        chk({tag, "/pc_vs_nomove"}, {31'd0, kind}, {31'd0, exp_pc});
        chk({tag, "/comp_pos"}, {28'd0, seen}, {28'd0, exp_pos});
        chk({tag, "/pulses"}, pulses, 1);
        chk({tag, "/overlap"}, both, 0);
        chk({tag, "/hold"}, {28'd0, comp_pos}, {28'd0, exp_pos});
        chk({tag, "/idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic start_in_done();
        int pulses;
        pulses = 0;
        @(negedge clk);
        bd = pk(C, C, E, P, P, E, E, E, E);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 3) begin
                start = 1'b0;
                chk("done_start/busy", {31'd0, busy}, 32'd0);
            end
            if (c == 4) chk("done_start/busy2", {31'd0, busy}, 32'd0);
            if (pc) pulses++;
        end
        chk("done_start/pulses", pulses, 1);
    endtask

    task automatic reset_mid_scan();
        int first;
        int pulses;
        logic [3:0] seen;
        first = -1; pulses = 0; seen = 4'd0;
        @(negedge clk);
        bd = pk(E, E, E, E, E, E, E, E, E);
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 5) reset = 1'b1;
            if (c == 6) begin
                reset = 1'b0;
                chk("rst_mid/busy", {31'd0, busy}, 32'd0);
                chk("rst_mid/comp_pos", {28'd0, comp_pos}, 32'hF);
            end
            if (c == 7) begin
                chk("rst_mid/restart", {31'd0, busy}, 32'd1);
                start = 1'b0;
            end
            if (pc) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    seen  = comp_pos;
                end
            end
        end
        chk("rst_mid/cycle", first, BLK ? 24 : 16);
        chk("rst_mid/pos", {28'd0, seen}, 32'd4);
        chk("rst_mid/pulses", pulses, 1);
    endtask

    task automatic board_change();
        int first;
        int pulses;
        logic [3:0] seen;
        first = -1; pulses = 0; seen = 4'd0;
        @(negedge clk);
        bd = pk(E, E, P, E, P, E, E, E, E);
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 3) bd = pk(C, C, E, E, E, E, E, E, E);
            if (c == 4) start = 1'b1;
            if (c == 5) start = 1'b0;
            if (pc) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    seen  = comp_pos;
                end
            end
        end
        chk("snap/cycle", first, BLK ? 17 : 11);
        chk("snap/pos", {28'd0, seen}, BLK ? 32'd6 : 32'd0);
        chk("snap/pulses", pulses, 1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        bd    = 18'd0;
        repeat (3) @(negedge clk);
        chk("reset/pc", {31'd0, pc}, 32'd0);
        chk("reset/no_move", {31'd0, no_move}, 32'd0);
        chk("reset/busy", {31'd0, busy}, 32'd0);
        chk("reset/comp_pos", {28'd0, comp_pos}, 32'hF);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("reset/idle_busy", {31'd0, busy}, 32'd0);

        run_move("empty", pk(E, E, E, E, E, E, E, E, E), BLK ? 18 : 10, 1'b1, 4'd4);
        run_move("win_beats_block", pk(C, C, E, P, P, E, E, E, E), 2, 1'b1, 4'd2);
        run_move("block_357", pk(E, E, P, E, P, E, E, E, E), BLK ? 17 : 11, 1'b1, BLK ? 4'd6 : 4'd0);
        run_move("block_147", pk(P, E, E, P, E, E, E, E, E), BLK ? 13 : 10, 1'b1, BLK ? 4'd6 : 4'd4);
        run_move("win_159", pk(C, E, E, E, C, E, E, E, E), 8, 1'b1, 4'd8);
        run_move("cell_11", pk(X, C, C, X, X, X, X, X, E), BLK ? 22 : 14, 1'b1, 4'd8);
        run_move("full", pk(C, P, C, C, P, P, P, C, C), BLK ? 27 : 19, 1'b0, 4'hF);
        start_in_done();
        reset_mid_scan();
        board_change();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
